// File: rtl/pcie_host_requester_if.sv
// Signal bundle between the PCIe host requester, its local command source and the TLP link.
// The master side is the requester block itself; the slave side is its environment.
interface pcie_host_requester_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_write;
   logic        req_is_config;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] tlpd;
   logic        tlpd_valid;
   logic [31:0] tlpr;
   logic        tlpr_valid;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        stray_rsp;

   modport master (
      input  req_valid, req_is_write, req_is_config, req_addr, req_wdata,
      input  tlpr, tlpr_valid,
      output req_ready, tlpd, tlpd_valid, rsp_valid, rsp_rdata, rsp_status, stray_rsp
   );

   modport slave (
      output req_valid, req_is_write, req_is_config, req_addr, req_wdata,
      output tlpr, tlpr_valid,
      input  req_ready, tlpd, tlpd_valid, rsp_valid, rsp_rdata, rsp_status, stray_rsp
   );
endinterface

// File: rtl/pcie_host_requester.sv
// Root-complex side requester: takes one command, sends a 3-beat request TLP,
// waits (with timeout) for the single-beat response and reports data and status.
module pcie_host_requester #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [7:0]  TLP_LENGTH     = 8'h01
) (
   input logic                   clk,
   input logic                   rst,
   pcie_host_requester_if.master bus
);
   localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND_HDR,
      SEND_ADDR,
      SEND_DATA,
      WAIT_RSP,
      DONE
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic          is_write_reg;
   logic          is_config_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic          req_ready_reg;
   logic [31:0]   tlpd_reg;
   logic          tlpd_valid_reg;
   logic          rsp_valid_reg;
   logic [31:0]   rsp_rdata_reg;
   logic [1:0]    rsp_status_reg;
   logic          stray_rsp_reg;

   function automatic logic [31:0] make_hdr(input logic is_write, input logic is_config);
      return {7'b0, is_config, 7'b0, is_write, TLP_LENGTH,
              1'b0, is_write, 3'b000, is_config, 2'b00};
   endfunction

   // Write acks must read back exactly 1; 0xDEADBEEF marks a bad BAR0 address.
   function automatic logic [1:0] rsp_code(input logic is_write, input logic is_config,
                                           input logic [31:0] data);
      if (is_write && data != 32'h0000_0001)
         return 2'b10;
      else if (!is_write && !is_config && data == 32'hDEAD_BEEF)
         return 2'b11;
      else
         return 2'b00;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         is_write_reg   <= 1'b0;
         is_config_reg  <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         req_ready_reg  <= 1'b1;
         tlpd_reg       <= '0;
         tlpd_valid_reg <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         rsp_rdata_reg  <= '0;
         rsp_status_reg <= 2'b00;
         stray_rsp_reg  <= 1'b0;
      end else begin
         tlpd_reg       <= '0;
         tlpd_valid_reg <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         stray_rsp_reg  <= bus.tlpr_valid && (state_reg != WAIT_RSP);

         case (state_reg)
            IDLE: begin
               if (bus.req_valid) begin
                  is_write_reg   <= bus.req_is_write;
                  is_config_reg  <= bus.req_is_config;
                  addr_reg       <= bus.req_addr;
                  wdata_reg      <= bus.req_wdata;
                  tlpd_reg       <= make_hdr(bus.req_is_write, bus.req_is_config);
                  tlpd_valid_reg <= 1'b1;
                  req_ready_reg  <= 1'b0;
                  state_reg      <= SEND_HDR;
               end
            end
            SEND_HDR: begin
               tlpd_reg       <= addr_reg;
               tlpd_valid_reg <= 1'b1;
               state_reg      <= SEND_ADDR;
            end
            SEND_ADDR: begin
               tlpd_reg       <= is_write_reg ? wdata_reg : 32'h0;
               tlpd_valid_reg <= 1'b1;
               state_reg      <= SEND_DATA;
            end
            SEND_DATA: begin
               cnt_reg   <= '0;
               state_reg <= WAIT_RSP;
            end
            WAIT_RSP: begin
               // A response arriving on the expiry cycle still counts as a response.
               if (bus.tlpr_valid) begin
                  rsp_rdata_reg  <= bus.tlpr;
                  rsp_status_reg <= rsp_code(is_write_reg, is_config_reg, bus.tlpr);
                  rsp_valid_reg  <= 1'b1;
                  state_reg      <= DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  rsp_rdata_reg  <= '0;
                  rsp_status_reg <= 2'b01;
                  rsp_valid_reg  <= 1'b1;
                  state_reg      <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               cnt_reg       <= '0;
               req_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: begin
               req_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.tlpd       = tlpd_reg;
   assign bus.tlpd_valid = tlpd_valid_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_rdata  = rsp_rdata_reg;
   assign bus.rsp_status = rsp_status_reg;
   assign bus.stray_rsp  = stray_rsp_reg;
endmodule

// File: tb/tb_pcie_host_requester.sv
// Scoreboard bench for pcie_host_requester: stimulus pushes expected beats, responses
// and stray pulses into queues; a negedge monitor pops and compares them.
module tb_pcie_host_requester;
   localparam int         T   = 8;
   localparam logic [7:0] LEN = 8'h01;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_err;
   int   n_txn;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic [1:0]  status;
   } rsp_t;

   beat_t beat_q[$];
   rsp_t  rsp_q[$];
   int    stray_q[$];

   logic [31:0] last_rdata;
   logic [1:0]  last_status;

   pcie_host_requester_if bus ();

   pcie_host_requester #(
      .TIMEOUT_CYCLES(T),
      .TLP_LENGTH    (LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: header layout, response status rules.
   function automatic logic [31:0] hdr_model(input bit w, input bit c);
      return (32'(c) << 24) | (32'(w) << 16) | (32'(LEN) << 8) | (32'(w) << 6) | (32'(c) << 2);
   endfunction

   function automatic logic [1:0] status_model(input bit w, input bit c, input logic [31:0] r);
      if (w)
         return (r == 32'd1) ? 2'b00 : 2'b10;
      if (!c && r == 32'hDEADBEEF)
         return 2'b11;
      return 2'b00;
   endfunction

   always @(negedge clk) begin : monitor
      beat_t b;
      rsp_t  r;
      int    s;
      if (rst) begin
         last_rdata  = '0;
         last_status = 2'b00;
      end else begin
         if (bus.tlpd_valid) begin
            if (beat_q.size() == 0) begin
               chk("beat_unexpected", 32'd1, 32'd0);
            end else begin
               b = beat_q.pop_front();
               chk("beat_cycle", b.cyc, cyc);
               chk("beat_data", bus.tlpd, b.data);
            end
         end else begin
            chk("tlpd_idle_zero", bus.tlpd, 32'h0);
         end

         if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_cycle", cyc, r.cyc);
               chk("rsp_rdata", bus.rsp_rdata, r.rdata);
               chk("rsp_status", 32'(bus.rsp_status), 32'(r.status));
               $display("rsp   cyc=%0d rdata=%h status=%b (expected %h/%b)",
                        cyc, bus.rsp_rdata, bus.rsp_status, r.rdata, r.status);
               last_rdata  = r.rdata;
               last_status = r.status;
            end
         end else begin
            chk("rsp_hold", {bus.rsp_status, bus.rsp_rdata[29:0]},
                {last_status, last_rdata[29:0]});
         end

         if (bus.stray_rsp) begin
            if (stray_q.size() == 0) begin
               chk("stray_unexpected", 32'd1, 32'd0);
            end else begin
               s = stray_q.pop_front();
               chk("stray_cycle", cyc, s);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, "_tlpd"}, bus.tlpd, 32'h0);
      chk({tag, "_tlpd_valid"}, 32'(bus.tlpd_valid), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
      chk({tag, "_rsp_status"}, 32'(bus.rsp_status), 32'd0);
      chk({tag, "_stray_rsp"}, 32'(bus.stray_rsp), 32'd0);
   endtask

   // k: WAIT_RSP cycle (1..T) carrying the response, 0 = none.
   // stray_j: cycle offset of a stray tlpr_valid (99 = DONE, -1 = none); rst_j: abort offset.
   task automatic do_txn(input bit w, input bit c, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] resp,
                         input int k, input int stray_j, input int rst_j);
      int    a;
      int    kk;
      int    jd;
      int    sj;
      beat_t b;
      rsp_t  r;
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid     = 1'b1;
      bus.req_is_write  = w;
      bus.req_is_config = c;
      bus.req_addr      = addr;
      bus.req_wdata     = wdata;
      a  = cyc + 1;
      kk = (k == 0) ? T : k;
      jd = 3 + kk;
      sj = (stray_j == 99) ? jd : stray_j;
      b.cyc = a;     b.data = hdr_model(w, c);      beat_q.push_back(b);
      b.cyc = a + 1; b.data = addr;                 beat_q.push_back(b);
      b.cyc = a + 2; b.data = w ? wdata : 32'h0;    beat_q.push_back(b);
      r.cyc = a + jd;
      if (k != 0) begin
         r.rdata  = resp;
         r.status = status_model(w, c, resp);
      end else begin
         r.rdata  = 32'h0;
         r.status = 2'b01;
      end
      rsp_q.push_back(r);
      $display("txn %0d: %s %s addr=%h wdata=%h resp=%h k=%0d stray=%0d rst=%0d",
               n_txn, w ? "WR" : "RD", c ? "CFG" : "MEM", addr, wdata, resp, k, sj, rst_j);
      n_txn++;
      for (int j = 0; j <= jd; j++) begin
         @(negedge clk);
         if (j == rst_j) begin
            void'(rsp_q.pop_back());
            rst            = 1'b1;
            bus.req_valid  = 1'b0;
            bus.tlpr_valid = 1'b0;
            #1;
            check_reset_outputs("abort");
            @(negedge clk);
            #1 rst = 1'b0;
            return;
         end
         // Junk commands outside IDLE must be ignored.
         bus.req_valid     = (j < jd) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.req_is_write  = 1'($urandom_range(0, 1));
         bus.req_is_config = 1'($urandom_range(0, 1));
         bus.req_addr      = $urandom;
         bus.req_wdata     = $urandom;
         bus.tlpr_valid    = (k != 0 && j == 2 + k) || (j == sj);
         bus.tlpr          = (k != 0 && j == 2 + k) ? resp : $urandom;
         if (j == sj) stray_q.push_back(a + j + 1);
      end
      @(negedge clk);
      bus.tlpr_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      n_txn = 0;
      last_rdata  = '0;
      last_status = 2'b00;
      rst = 1'b1;
      bus.req_valid     = 1'b0;
      bus.req_is_write  = 1'b0;
      bus.req_is_config = 1'b0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.tlpr          = '0;
      bus.tlpr_valid    = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      #1 rst = 1'b0;
      @(negedge clk);

      do_txn(1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h1234_5678, 1, -1, -1);
      do_txn(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0001, 1, -1, -1);
      do_txn(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1, -1, -1);
      do_txn(1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 3, -1, -1);
      do_txn(1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0,         0, -1, -1);
      do_txn(1'b0, 1'b0, 32'h0000_0024, 32'h0,         32'hA5A5_A5A5, T, -1, -1);
      do_txn(1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h0BAD_F00D, 2,  1, -1);
      do_txn(1'b1, 1'b1, 32'h0000_0004, 32'h1111_2222, 32'h0000_0001, 5, -1,  4);
      do_txn(1'b1, 1'b1, 32'h0000_000C, 32'h3333_4444, 32'h0000_0001, 1, -1, -1);

      for (int i = 0; i < 150; i++) begin
         bit          w;
         bit          c;
         int          k;
         int          sel;
         int          sj;
         logic [31:0] resp;
         repeat ($urandom_range(0, 2)) begin
            bus.tlpr_valid = 1'($urandom_range(0, 1));
            bus.tlpr       = $urandom;
            if (bus.tlpr_valid) stray_q.push_back(cyc + 1);
            @(negedge clk);
            bus.tlpr_valid = 1'b0;
         end
         w   = 1'($urandom_range(0, 1));
         c   = 1'($urandom_range(0, 1));
         k   = $urandom_range(0, T + 2);
         if (k > T) k = 0;
         sel = $urandom_range(0, 3);
         resp = (sel == 0) ? 32'h1 : (sel == 1) ? 32'h0 : (sel == 2) ? 32'hDEADBEEF : $urandom;
         sel = $urandom_range(0, 5);
         sj  = (sel < 2) ? -1 : (sel == 5) ? 99 : sel - 2;
         do_txn(w, c, {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, resp, k, sj, -1);
      end

      repeat (3) @(negedge clk);
      chk("beat_q_drained", beat_q.size(), 32'd0);
      chk("rsp_q_drained", rsp_q.size(), 32'd0);
      chk("stray_q_drained", stray_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pcie_host_requester.md
Name: pcie_host_requester

Overview:
- Initiator (root-complex side) for the simplified PCIe transaction-layer link served by the endpoint block.
- Accepts one command at a time on a valid/ready request port.
- Serializes each command into a fixed 3-beat request TLP on tlpd/tlpd_valid.
- Waits for the single-beat response on tlpr/tlpr_valid with a timeout, then returns data and status to the local requester.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT_RSP cycles without tlpr_valid before the transaction is closed as timed out; legal range 1..65535.
- TLP_LENGTH, 8'h01: value placed in header bits [15:8].

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  command valid.
- req_ready  output  1  block can accept a command; high only in IDLE.
- req_is_write  input  1  1 = write, 0 = read.
- req_is_config  input  1  1 = configuration space, 0 = BAR0 memory space.
- req_addr  input  32  target address; byte address, word aligned for memory.
- req_wdata  input  32  write data; ignored for reads.
- tlpd  output  32  request TLP beat.
- tlpd_valid  output  1  request beat valid.
- tlpr  input  32  response data.
- tlpr_valid  input  1  response valid.
- rsp_valid  output  1  one-cycle pulse: transaction complete.
- rsp_rdata  output  32  read data; 0 on timeout; the received tlpr word otherwise.
- rsp_status  output  2  00 ok, 01 timeout, 10 write-ack mismatch, 11 bad address.
- stray_rsp  output  1  one-cycle pulse: tlpr_valid seen outside WAIT_RSP.

Behaviour:
- Reset (async, rst=1): state IDLE.
  - Outputs: req_ready=1, tlpd=0, tlpd_valid=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, stray_rsp=0.
  - Timeout counter and captured command cleared.
  - Reset mid-transaction aborts it: no rsp_valid, tlpd_valid drops immediately.
- All outputs are registered.
- States: IDLE -> SEND_HDR -> SEND_ADDR -> SEND_DATA -> WAIT_RSP -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid at edge N, capture is_write, is_config, addr, wdata; go to SEND_HDR.
- SEND_HDR (cycle N+1): tlpd_valid=1; tlpd fields:
  - [7:0] type = {1'b0, is_write, 3'b000, is_config, 2'b00}
  - [15:8] = TLP_LENGTH
  - [16] = is_write
  - [24] = is_config
  - all other bits 0
- SEND_ADDR (N+2): tlpd_valid=1, tlpd=addr.
- SEND_DATA (N+3): tlpd_valid=1, tlpd=wdata for writes, 32'h0 for reads. Data beat is always sent.
- Beat timing: tlpd_valid is high for exactly 3 consecutive cycles, with no backpressure. In all other states tlpd_valid=0 and tlpd=0.
- WAIT_RSP:
  - Counter starts at 0 on entry and increments each cycle tlpr_valid=0.
  - On the first tlpr_valid=1: capture tlpr into rsp_rdata and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with tlpr_valid=0: rsp_rdata=0, status=01, go to DONE.
  - tlpr_valid in the same cycle as timeout expiry: the response wins (normal capture, status from the rules below).
- Status on a captured response:
  - Write, tlpr!=32'h00000001: 10.
  - Memory read, tlpr==32'hDEADBEEF: 11.
  - Otherwise: 00.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_status are valid in that cycle and hold until the next DONE.
  - req_ready=0; next state IDLE.
- Stray responses:
  - tlpr_valid in any state other than WAIT_RSP, including SEND_* and DONE, pulses stray_rsp the next cycle.
  - The stray word is otherwise ignored.
  - Only the first tlpr_valid cycle in WAIT_RSP is consumed; later ones count as stray.
- req_valid outside IDLE is ignored because req_ready=0; commands are never queued.
- Minimum transaction: 5 cycles from acceptance to rsp_valid, when the response arrives on the first WAIT_RSP cycle.
- Back-to-back: the next command can be accepted in the cycle after DONE.
- Counter width: $clog2(TIMEOUT_CYCLES+1) bits; the counter never wraps.

Test Plan:
- Config read addr 0x00; endpoint model returns 0x12345678 one cycle after the data beat.
  - Required: beats 0x01000104, 0x00000000, 0x00000000.
  - Required: rsp_valid with rdata=0x12345678, status=00, 5 cycles after acceptance.
- Memory write addr 0x10, data 0xCAFEF00D, response 0x00000001.
  - Required: beats 0x00010140, 0x00000010, 0xCAFEF00D.
  - Required: status=00.
  - Repeat with response 0x00000000: status=10.
- Memory read addr 0x400, response 0xDEADBEEF.
  - Required: rdata=0xDEADBEEF, status=11.
- No response, TIMEOUT_CYCLES=8.
  - Required: rsp_valid exactly 8 cycles after entering WAIT_RSP, rdata=0, status=01.
  - Variant: tlpr_valid on the 8th cycle gives a normal capture instead of a timeout.
- tlpr_valid pulsed during SEND_ADDR: stray_rsp pulses once, and the transaction still completes on the later real response.
- Assert rst during WAIT_RSP, then issue a new command.
  - Required: all outputs return to their reset values asynchronously, no rsp_valid for the aborted command, and the new command proceeds normally.
